// File: rtl/lift_pass_sched.sv
// Sequences the column/row lifting engine over an N x N image, one job per
// (level, pass, line, step), forward or inverse, with a WAIT-state watchdog.
module lift_pass_sched #(
  parameter int LOG_N   = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_fsm,
  input  logic             start,
  input  logic             inverse,
  input  logic [1:0]       levels,
  input  logic             abort,
  input  logic             eng_done,
  output logic             eng_start,
  output logic             eng_row,
  output logic [1:0]       eng_level,
  output logic [LOG_N-1:0] eng_line,
  output logic [LOG_N:0]   eng_len,
  output logic [3:0]       eng_flgs,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [LOG_N:0] N_FULL = {1'b1, {LOG_N{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic             inv_reg, inv_next;
  logic [1:0]       levels_reg, levels_next;
  logic [1:0]       level_reg, level_next;
  logic [LOG_N-1:0] line_reg, line_next;
  logic             pass_reg, pass_next;
  logic             step_reg, step_next;
  logic [WD_W-1:0]  wdog_reg, wdog_next;
  logic             err_reg, err_next;

  logic [LOG_N:0]   n_cur;
  logic             line_last, level_last, job_last, active;

  // pass_reg/step_reg count in execution order; inv_reg maps them onto
  // the physical pass (row/column) and step (odd/even).
  always_comb begin
    n_cur      = N_FULL >> level_reg;
    line_last  = (line_reg == LOG_N'(n_cur - 1'b1));
    level_last = inv_reg ? (level_reg == 2'd0) : (level_reg == levels_reg - 2'd1);
    job_last   = step_reg & pass_reg & line_last & level_last;
  end

  always_comb begin
    state_next  = state_reg;
    inv_next    = inv_reg;
    levels_next = levels_reg;
    level_next  = level_reg;
    line_next   = line_reg;
    pass_next   = pass_reg;
    step_next   = step_reg;
    wdog_next   = wdog_reg;
    err_next    = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          inv_next    = inverse;
          levels_next = levels;
          err_next    = 1'b0;
          line_next   = '0;
          pass_next   = 1'b0;
          step_next   = 1'b0;
          if (levels == 2'd0) begin
            level_next = 2'd0;
            state_next = S_DONE;
          end else begin
            level_next = inverse ? (levels - 2'd1) : 2'd0;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wdog_next  = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          state_next = S_NEXT;
        end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
          level_next = 2'd0;
          line_next  = '0;
          pass_next  = 1'b0;
          step_next  = 1'b0;
          wdog_next  = '0;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      S_NEXT: begin
        state_next = job_last ? S_DONE : S_ISSUE;
        if (!step_reg) begin
          step_next = 1'b1;
        end else begin
          step_next = 1'b0;
          if (!line_last) begin
            line_next = line_reg + 1'b1;
          end else begin
            line_next = '0;
            pass_next = ~pass_reg;
            if (pass_reg)
              level_next = inv_reg ? (level_reg - 2'd1) : (level_reg + 2'd1);
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        level_next = 2'd0;
        line_next  = '0;
        pass_next  = 1'b0;
        step_next  = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase

    // abort overrides everything, including a start accepted this cycle
    if (abort) begin
      state_next  = S_IDLE;
      inv_next    = inv_reg;
      levels_next = levels_reg;
      err_next    = err_reg;
      level_next  = 2'd0;
      line_next   = '0;
      pass_next   = 1'b0;
      step_next   = 1'b0;
      wdog_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_fsm) begin
      state_reg  <= S_IDLE;
      inv_reg    <= 1'b0;
      levels_reg <= 2'd0;
      level_reg  <= 2'd0;
      line_reg   <= '0;
      pass_reg   <= 1'b0;
      step_reg   <= 1'b0;
      wdog_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      inv_reg    <= inv_next;
      levels_reg <= levels_next;
      level_reg  <= level_next;
      line_reg   <= line_next;
      pass_reg   <= pass_next;
      step_reg   <= step_next;
      wdog_reg   <= wdog_next;
      err_reg    <= err_next;
    end
  end

  // Job fields are only meaningful while a job is in flight; zero otherwise.
  always_comb begin
    active    = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_NEXT);
    eng_start = (state_reg == S_ISSUE);
    eng_row   = active & (pass_reg ^ inv_reg);
    eng_level = active ? level_reg : 2'd0;
    eng_line  = active ? line_reg : '0;
    eng_len   = active ? n_cur : '0;
    eng_flgs  = active ? {1'b0, 1'b1, step_reg ^ inv_reg, ~inv_reg} : 4'd0;
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
    err       = err_reg;
  end

endmodule
